// File: rtl/dispatch_source.sv
// dispatch_source: front-end sequencer between the host command decoder and
// the spiking-network core. Accepts RUN/SPK/SNC/CLR commands over valid/ready
// and converts each into cycle-accurate network and sink controls.
// Optional feature macro: DISPATCH_SPK_DROP_CNT_EN adds spk_drop_cnt, a
// saturating count of out-of-range SPK commands that were dropped.
module dispatch_source #(
    parameter int NUM_INP   = 4,
    parameter int IDX_WIDTH = (NUM_INP > 1) ? $clog2(NUM_INP) : 1,
    parameter int CHG_WIDTH = 8,
    parameter int RUN_WIDTH = 16,
    parameter int OPR_WIDTH = (RUN_WIDTH > IDX_WIDTH + CHG_WIDTH) ?
                              RUN_WIDTH : IDX_WIDTH + CHG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_opc,
    input  logic [OPR_WIDTH-1:0] cmd_opr,
    output logic                 net_run,
    output logic                 net_inp_valid,
    output logic [IDX_WIDTH-1:0] net_inp_idx,
    output logic [CHG_WIDTH-1:0] net_inp_chg,
    output logic                 net_clear,
    output logic                 snc_req,
    input  logic                 snc_ack,
    output logic [1:0]           sink_flg
`ifdef DISPATCH_SPK_DROP_CNT_EN
    ,
    output logic [7:0]           spk_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        OPC_RUN = 2'd0,
        OPC_SPK = 2'd1,
        OPC_SNC = 2'd2,
        OPC_CLR = 2'd3
    } opc_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SYNC = 2'd2,
        S_CLR  = 2'd3
    } state_e;

    // NUM_INP always fits in IDX_WIDTH+1 bits, so the range check is exact.
    localparam logic [IDX_WIDTH:0] C_NUM_INP = (IDX_WIDTH + 1)'(NUM_INP);

    state_e                 r_state;
    logic [RUN_WIDTH-1:0]   r_run_cnt;
    logic                   r_net_run;
    logic                   r_net_inp_valid;
    logic [IDX_WIDTH-1:0]   r_net_inp_idx;
    logic [CHG_WIDTH-1:0]   r_net_inp_chg;
    logic                   r_net_clear;
    logic                   r_snc_req;
    logic [1:0]             r_sink_flg;

    opc_e                   w_opc;
    logic                   w_accept;
    logic [RUN_WIDTH-1:0]   w_run_cnt;
    logic [IDX_WIDTH-1:0]   w_spk_idx;
    logic [CHG_WIDTH-1:0]   w_spk_chg;
    logic                   w_spk_in_range;

    assign cmd_ready      = (r_state == S_IDLE) && !rst;
    assign w_accept       = cmd_valid && cmd_ready;
    assign w_opc          = opc_e'(cmd_opc);
    assign w_run_cnt      = cmd_opr[RUN_WIDTH-1:0];
    assign w_spk_chg      = cmd_opr[CHG_WIDTH-1:0];
    assign w_spk_idx      = cmd_opr[IDX_WIDTH+CHG_WIDTH-1:CHG_WIDTH];
    assign w_spk_in_range = ({1'b0, w_spk_idx} < C_NUM_INP);

    // Command FSM with registered network and sink outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_run_cnt       <= '0;
            r_net_run       <= 1'b0;
            r_net_inp_valid <= 1'b0;
            r_net_inp_idx   <= '0;
            r_net_inp_chg   <= '0;
            r_net_clear     <= 1'b0;
            r_snc_req       <= 1'b0;
            r_sink_flg      <= '0;
        end else begin
            r_net_inp_valid <= 1'b0;
            r_net_clear     <= 1'b0;
            r_sink_flg      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_opc)
                            OPC_SPK: begin
                                if (w_spk_in_range) begin
                                    r_net_inp_valid <= 1'b1;
                                    r_net_inp_idx   <= w_spk_idx;
                                    r_net_inp_chg   <= w_spk_chg;
                                end
                            end
                            OPC_RUN: begin
                                if (w_run_cnt != '0) begin
                                    r_run_cnt <= w_run_cnt;
                                    r_net_run <= 1'b1;
                                    r_state   <= S_RUN;
                                end
                            end
                            OPC_SNC: begin
                                r_snc_req <= 1'b1;
                                r_state   <= S_SYNC;
                            end
                            default: begin
                                r_net_clear <= 1'b1;
                                r_sink_flg  <= 2'b10;
                                r_state     <= S_CLR;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    // net_run was raised on entry, so it drops when the last
                    // remaining count is consumed, giving exactly n high cycles.
                    r_run_cnt <= r_run_cnt - RUN_WIDTH'(1);
                    if (r_run_cnt == RUN_WIDTH'(1)) begin
                        r_net_run <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_SYNC: begin
                    if (snc_ack) begin
                        r_snc_req  <= 1'b0;
                        r_sink_flg <= 2'b01;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign net_run       = r_net_run;
    assign net_inp_valid = r_net_inp_valid;
    assign net_inp_idx   = r_net_inp_idx;
    assign net_inp_chg   = r_net_inp_chg;
    assign net_clear     = r_net_clear;
    assign snc_req       = r_snc_req;
    assign sink_flg      = r_sink_flg;

`ifdef DISPATCH_SPK_DROP_CNT_EN
    logic       w_spk_drop;
    logic [7:0] r_spk_drop_cnt;

    assign w_spk_drop = w_accept && (w_opc == OPC_SPK) && !w_spk_in_range;

    // Saturating counter of dropped out-of-range spikes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spk_drop_cnt <= '0;
        end else if (w_spk_drop && (r_spk_drop_cnt != 8'hFF)) begin
            r_spk_drop_cnt <= r_spk_drop_cnt + 8'd1;
        end
    end

    assign spk_drop_cnt = r_spk_drop_cnt;
`endif

endmodule

// File: tb/tb_dispatch_source.sv
// Directed testbench for dispatch_source. Uses NUM_INP=3 so that a 2-bit
// spike index can address an out-of-range input (idx=3) and exercise drops.
module tb_dispatch_source;

    localparam int NUM_INP   = 3;
    localparam int IDX_WIDTH = 2;
    localparam int CHG_WIDTH = 8;
    localparam int RUN_WIDTH = 16;
    localparam int OPR_WIDTH = 16;

    logic                 clk;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_opc;
    logic [OPR_WIDTH-1:0] cmd_opr;
    logic                 net_run;
    logic                 net_inp_valid;
    logic [IDX_WIDTH-1:0] net_inp_idx;
    logic [CHG_WIDTH-1:0] net_inp_chg;
    logic                 net_clear;
    logic                 snc_req;
    logic                 snc_ack;
    logic [1:0]           sink_flg;
`ifdef DISPATCH_SPK_DROP_CNT_EN
    logic [7:0]           spk_drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dispatch_source #(
        .NUM_INP  (NUM_INP),
        .IDX_WIDTH(IDX_WIDTH),
        .CHG_WIDTH(CHG_WIDTH),
        .RUN_WIDTH(RUN_WIDTH),
        .OPR_WIDTH(OPR_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opc      (cmd_opc),
        .cmd_opr      (cmd_opr),
        .net_run      (net_run),
        .net_inp_valid(net_inp_valid),
        .net_inp_idx  (net_inp_idx),
        .net_inp_chg  (net_inp_chg),
        .net_clear    (net_clear),
        .snc_req      (snc_req),
        .snc_ack      (snc_ack),
        .sink_flg     (sink_flg)
`ifdef DISPATCH_SPK_DROP_CNT_EN
        ,
        .spk_drop_cnt (spk_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] opc, input logic [15:0] opr);
        cmd_valid = 1'b1;
        cmd_opc   = opc;
        cmd_opr   = opr;
    endtask

    task automatic idle_in();
        cmd_valid = 1'b0;
        cmd_opc   = 2'd0;
        cmd_opr   = '0;
    endtask

    initial begin
        rst     = 1'b1;
        snc_ack = 1'b0;
        idle_in();
        cyc();
        cyc();
        // Reset state
        chk("rst_ready", cmd_ready, 0);
        chk("rst_run", net_run, 0);
        chk("rst_inp_valid", net_inp_valid, 0);
        chk("rst_idx", net_inp_idx, 0);
        chk("rst_chg", net_inp_chg, 0);
        chk("rst_clear", net_clear, 0);
        chk("rst_snc_req", snc_req, 0);
        chk("rst_flg", sink_flg, 0);
`ifdef DISPATCH_SPK_DROP_CNT_EN
        chk("rst_drop_cnt", spk_drop_cnt, 0);
`endif
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // SPK idx=2 chg=-5
        drive(2'd1, 16'h02FB);
        cyc();
        idle_in();
        chk("spk_valid", net_inp_valid, 1);
        chk("spk_idx", net_inp_idx, 2);
        chk("spk_chg", net_inp_chg, 8'hFB);
        cyc();
        chk("spk_pulse_end", net_inp_valid, 0);
        chk("spk_idx_hold", net_inp_idx, 2);
        chk("spk_chg_hold", net_inp_chg, 8'hFB);

        // Three back-to-back SPKs
        drive(2'd1, 16'h0011);
        chk("b2b_ready0", cmd_ready, 1);
        cyc();
        chk("b2b_valid0", net_inp_valid, 1);
        chk("b2b_idx0", net_inp_idx, 0);
        chk("b2b_chg0", net_inp_chg, 8'h11);
        drive(2'd1, 16'h0122);
        chk("b2b_ready1", cmd_ready, 1);
        cyc();
        chk("b2b_valid1", net_inp_valid, 1);
        chk("b2b_idx1", net_inp_idx, 1);
        chk("b2b_chg1", net_inp_chg, 8'h22);
        drive(2'd1, 16'h0280);
        chk("b2b_ready2", cmd_ready, 1);
        cyc();
        idle_in();
        chk("b2b_valid2", net_inp_valid, 1);
        chk("b2b_idx2", net_inp_idx, 2);
        chk("b2b_chg2", net_inp_chg, 8'h80);
        cyc();
        chk("b2b_end", net_inp_valid, 0);

        // RUN count=5
        drive(2'd0, 16'd5);
        cyc();
        idle_in();
        for (int i = 0; i < 7; i++) begin
            chk("run5_net_run", net_run, (i < 5) ? 1 : 0);
            chk("run5_ready", cmd_ready, (i >= 5) ? 1 : 0);
            chk("run5_no_clear", net_clear, 0);
            cyc();
        end

        // RUN count=0 is a no-op
        drive(2'd0, 16'd0);
        chk("run0_ready_pre", cmd_ready, 1);
        cyc();
        idle_in();
        chk("run0_net_run", net_run, 0);
        chk("run0_ready", cmd_ready, 1);
        cyc();
        chk("run0_net_run2", net_run, 0);

        // snc_ack while idle is ignored
        snc_ack = 1'b1;
        cyc();
        snc_ack = 1'b0;
        chk("ack_idle_flg", sink_flg, 0);
        chk("ack_idle_req", snc_req, 0);
        chk("ack_idle_ready", cmd_ready, 1);

        // SNC with ack after 7 cycles of request
        drive(2'd2, 16'd0);
        cyc();
        idle_in();
        for (int i = 1; i <= 7; i++) begin
            chk("snc_req_high", snc_req, 1);
            chk("snc_ready_low", cmd_ready, 0);
            chk("snc_flg_quiet", sink_flg, 0);
            if (i == 7) snc_ack = 1'b1;
            cyc();
        end
        snc_ack = 1'b0;
        chk("snc_req_drop", snc_req, 0);
        chk("snc_flg_pulse", sink_flg, 2'b01);
        chk("snc_ready_back", cmd_ready, 1);
        cyc();
        chk("snc_flg_end", sink_flg, 0);

        // CLR
        drive(2'd3, 16'd0);
        cyc();
        idle_in();
        chk("clr_pulse", net_clear, 1);
        chk("clr_flg", sink_flg, 2'b10);
        chk("clr_ready_low", cmd_ready, 0);
        chk("clr_no_run", net_run, 0);
        cyc();
        chk("clr_end", net_clear, 0);
        chk("clr_flg_end", sink_flg, 0);
        chk("clr_ready_back", cmd_ready, 1);

        // Reset at cycle 3 of RUN 10
        drive(2'd0, 16'd10);
        cyc();
        idle_in();
        chk("rrun_c1", net_run, 1);
        cyc();
        chk("rrun_c2", net_run, 1);
        cyc();
        chk("rrun_c3", net_run, 1);
        rst = 1'b1;
        #1;
        chk("rrun_ready_in_rst", cmd_ready, 0);
        cyc();
        chk("rrun_abort", net_run, 0);
        rst = 1'b0;
        #1;
        chk("rrun_idle_ready", cmd_ready, 1);
        cyc();
        chk("rrun_stays_off", net_run, 0);
        chk("rrun_idx_cleared", net_inp_idx, 0);

        // Out-of-range SPK is dropped; previous idx/chg held
        drive(2'd1, 16'h0142);
        cyc();
        idle_in();
        chk("pre_drop_valid", net_inp_valid, 1);
        drive(2'd1, 16'h037F);
        cyc();
        idle_in();
        chk("drop_no_valid", net_inp_valid, 0);
        chk("drop_idx_hold", net_inp_idx, 1);
        chk("drop_chg_hold", net_inp_chg, 8'h42);
        chk("drop_ready", cmd_ready, 1);
`ifdef DISPATCH_SPK_DROP_CNT_EN
        chk("drop_cnt_1", spk_drop_cnt, 1);
        drive(2'd1, 16'h037F);
        for (int i = 0; i < 299; i++) cyc();
        idle_in();
        cyc();
        chk("drop_cnt_sat", spk_drop_cnt, 255);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("drop_cnt_rst", spk_drop_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
